// File: rtl/apb_reg_slice.sv
// APB3 register slice: fully retimes one transfer from the upstream port onto the downstream port.
// Define APB_REG_SLICE_TIMEOUT_EN to abort downstream slaves that never assert m_pready.
module apb_reg_slice #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] s_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s_pwdata,
  input  logic                      s_pwrite,
  input  logic                      s_psel,
  input  logic                      s_penable,
  output logic [APB_DATA_WIDTH-1:0] s_prdata,
  output logic                      s_pready,
  output logic                      s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0] m_paddr,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata,
  output logic                      m_pwrite,
  output logic                      m_psel,
  output logic                      m_penable,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;

  logic accept;
  logic timeout;

  assign accept = s_psel && s_penable;

`ifdef APB_REG_SLICE_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == StAccess) && !m_pready && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if ((state_q == StAccess) && !m_pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (m_pready || timeout) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of the output registers; strobes follow the next state so they are flop-driven.
  always_comb begin
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    psel_d    = (state_d == StSetup) || (state_d == StAccess);
    penable_d = (state_d == StAccess);
    pready_d  = (state_d == StResp);

    if ((state_q == StIdle) && accept) begin
      paddr_d  = s_paddr;
      pwdata_d = s_pwdata;
      pwrite_d = s_pwrite;
    end

    if (state_q == StAccess) begin
      if (m_pready) begin
        prdata_d  = m_prdata;
        pslverr_d = m_pslverr;
      end else if (timeout) begin
        prdata_d  = '0;
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign m_pwrite  = pwrite_q;
  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign s_prdata  = prdata_q;
  assign s_pready  = pready_q;
  assign s_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slice.sv
// Scoreboard bench for apb_reg_slice: directed upstream transfers against a programmable
// downstream responder; monitors compare downstream setup phases and upstream responses.
module tb_apb_reg_slice;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic        s_pwrite, s_psel, s_penable, s_pready, s_pslverr;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pwrite, m_psel, m_penable, m_pready, m_pslverr;

  apb_reg_slice #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_paddr  (s_paddr),
    .s_pwdata (s_pwdata),
    .s_pwrite (s_pwrite),
    .s_psel   (s_psel),
    .s_penable(s_penable),
    .s_prdata (s_prdata),
    .s_pready (s_pready),
    .s_pslverr(s_pslverr),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_pwrite (m_pwrite),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_prdata (m_prdata),
    .m_pready (m_pready),
    .m_pslverr(m_pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    int          cyc;
  } ds_t;

  resp_t rsp_q[$];
  ds_t   ds_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Downstream responder configuration
  logic        ds_en = 1'b0;
  int          ds_waits = 0;
  logic [31:0] ds_rdata = '0;
  logic        ds_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Downstream slave: ready after ds_waits ACCESS cycles
  initial begin
    int acc;
    acc = 0;
    m_pready  = 1'b0;
    m_prdata  = '0;
    m_pslverr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (ds_en) begin
        if (m_psel && m_penable) begin
          if (acc == ds_waits) begin
            m_pready  = 1'b1;
            m_prdata  = ds_rdata;
            m_pslverr = ds_err;
          end else begin
            m_pready  = 1'b0;
            m_prdata  = 32'hBAD0_0BAD;
            m_pslverr = 1'b0;
          end
          acc++;
        end else begin
          acc      = 0;
          m_pready = 1'b0;
        end
      end
    end
  end

  // Downstream monitor: one pop per SETUP cycle
  initial begin
    ds_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rst_ni && m_psel && !m_penable) begin
        if (ds_q.size() == 0) begin
          chk("ds_unexpected_setup", 32'd1, 32'd0);
        end else begin
          e = ds_q.pop_front();
          chk("ds_paddr", m_paddr, e.addr);
          chk("ds_pwdata", m_pwdata, e.data);
          chk("ds_pwrite", m_pwrite, e.wr);
          chk("ds_setup_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Upstream response monitor
  initial begin
    resp_t e;
    logic  prev;
    prev = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (s_pready) begin
        chk("pready_single_pulse", prev, 1'b0);
        if (rsp_q.size() == 0) begin
          chk("us_unexpected_pready", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("us_prdata", s_prdata, e.rdata);
          chk("us_pslverr", s_pslverr, e.err);
          chk("us_pready_cycle", cyc, e.cyc);
        end
      end
      prev = s_pready;
    end
  end

  // One upstream transfer; exp_lat is the s_pready cycle relative to access-phase cycle 0
  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                          input int waits, input logic [31:0] rd, input logic err_in,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int c0;
    int n;
    @(negedge clk_i);
    s_paddr   = addr;
    s_pwdata  = data;
    s_pwrite  = wr;
    s_psel    = 1'b1;
    s_penable = 1'b0;
    ds_waits  = waits;
    ds_rdata  = rd;
    ds_err    = err_in;
    @(negedge clk_i);
    s_penable = 1'b1;
    c0 = cyc;
    ds_q.push_back('{addr: addr, data: data, wr: wr, cyc: c0 + 1});
    rsp_q.push_back('{rdata: exp_rd, err: exp_err, cyc: c0 + exp_lat});
    n = 0;
    while (!s_pready && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!s_pready) chk("us_pready_timeout", 32'd0, 32'd1);
    s_psel    = 1'b0;
    s_penable = 1'b0;
  endtask

  initial begin
    int c0;
    int n;
    rst_ni    = 1'b0;
    s_paddr   = '0;
    s_pwdata  = '0;
    s_pwrite  = 1'b0;
    s_psel    = 1'b0;
    s_penable = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      s_paddr   = $urandom;
      s_pwdata  = $urandom;
      s_pwrite  = 1'($urandom);
      s_psel    = 1'($urandom);
      s_penable = 1'($urandom);
      m_prdata  = $urandom;
      m_pready  = 1'($urandom);
      m_pslverr = 1'($urandom);
      #1;
      chk("rst_outputs_zero",
          32'(|{s_prdata, s_pready, s_pslverr, m_paddr, m_pwdata, m_pwrite, m_psel, m_penable}),
          32'd0);
    end
    @(negedge clk_i);
    s_psel    = 1'b0;
    s_penable = 1'b0;
    m_pready  = 1'b0;
    ds_en     = 1'b1;
    rst_ni    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("idle_no_psel", m_psel, 1'b0);
    end

    // Zero-wait write
    apb_xfer(32'h1A10_0004, 32'hDEAD_BEEF, 1'b1, 0, 32'h0000_0011, 1'b0,
             32'h0000_0011, 1'b0, 3);
    // Read with 3 wait states and slave error
    apb_xfer(32'h1A10_0008, 32'h0, 1'b0, 3, 32'h0000_00A5, 1'b1,
             32'h0000_00A5, 1'b1, 6);
    // Back-to-back write then read
    apb_xfer(32'h4000_0010, 32'h1234_5678, 1'b1, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3);
    apb_xfer(32'h4000_0014, 32'hFFFF_FFFF, 1'b0, 1, 32'h5A5A_0001, 1'b0,
             32'h5A5A_0001, 1'b0, 4);
    chk("m_paddr_hold", m_paddr, 32'h4000_0014);
    chk("m_pwrite_hold", m_pwrite, 1'b0);

`ifdef APB_REG_SLICE_TIMEOUT_EN
    // Never ready: abort after 4 ACCESS cycles
    apb_xfer(32'h5000_0000, 32'h0, 1'b0, 1000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 6);
    // Ready on the 4th ACCESS cycle wins over the abort
    apb_xfer(32'h5000_0004, 32'h0, 1'b0, 3, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0, 6);
    apb_xfer(32'h5000_0008, 32'h0, 1'b0, 3, 32'h0000_0088, 1'b1, 32'h0000_0088, 1'b1, 6);
`endif

    // Reset asserted during ACCESS
    @(negedge clk_i);
    s_paddr   = 32'h6000_0020;
    s_pwdata  = 32'hCAFE_F00D;
    s_pwrite  = 1'b1;
    s_psel    = 1'b1;
    s_penable = 1'b0;
    ds_waits  = 1000;
    @(negedge clk_i);
    s_penable = 1'b1;
    c0 = cyc;
    ds_q.push_back('{addr: 32'h6000_0020, data: 32'hCAFE_F00D, wr: 1'b1, cyc: c0 + 1});
    n = 0;
    while (!m_penable && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("reach_access", m_penable, 1'b1);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_psel", m_psel, 1'b0);
    chk("async_rst_penable", m_penable, 1'b0);
    chk("async_rst_paddr", m_paddr, 32'h0);
    s_psel    = 1'b0;
    s_penable = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    apb_xfer(32'h7000_0030, 32'h0BAD_CAFE, 1'b1, 2, 32'h0000_0042, 1'b0,
             32'h0000_0042, 1'b0, 5);

    repeat (3) @(negedge clk_i);
    chk("ds_queue_empty", ds_q.size(), 32'd0);
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
